// File: rtl/sfpp_pkg.sv
// Shared field widths, IEEE-754 single layout and the truncating normal-operand multiply.
package sfpp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned WORD_W = 1 + EXP_W + FRAC_W;
    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned PROD_W = 2 * MANT_W;
    localparam int unsigned EXPC_W = 10;

    localparam logic [EXP_W-1:0] SFPP_BIAS = 8'd127;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } sfpp_t;

    // Hidden bit always assumed 1; exponent wraps modulo 2^8, fraction truncated.
    function automatic sfpp_t sfpp_mul(input sfpp_t a, input sfpp_t b);
        logic [PROD_W-1:0] prod;
        logic [EXPC_W-1:0] exp_sum;
        sfpp_t             res;
        prod    = PROD_W'({1'b1, a.frac}) * PROD_W'({1'b1, b.frac});
        exp_sum = EXPC_W'(a.exp) + EXPC_W'(b.exp) - EXPC_W'(SFPP_BIAS);
        res.sign = a.sign ^ b.sign;
        if (prod[PROD_W-1]) begin
            res.exp  = EXP_W'(exp_sum + EXPC_W'(1));
            res.frac = FRAC_W'(prod >> MANT_W);
        end else begin
            res.exp  = EXP_W'(exp_sum);
            res.frac = FRAC_W'(prod >> FRAC_W);
        end
        return res;
    endfunction

endpackage

// File: rtl/sfpp_mul_pipe.sv
// MUL_LAT-stage FP multiplier carrying valid and tag; optional SFPP_ZERO_FLUSH_EN flushes exp==0 operands.
module sfpp_mul_pipe
    import sfpp_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned TAG_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  sfpp_t            in_a_i,
    input  sfpp_t            in_b_i,
    output logic             out_valid_o,
    output logic [TAG_W-1:0] out_tag_o,
    output sfpp_t            out_data_o
);

    logic             op_v_q;
    logic [TAG_W-1:0] op_tag_q;
    sfpp_t            op_a_q;
    sfpp_t            op_b_q;
    sfpp_t            prod_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_v_q <= 1'b0;
        end else begin
            op_v_q <= in_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid_i) begin
            op_tag_q <= in_tag_i;
            op_a_q   <= in_a_i;
            op_b_q   <= in_b_i;
        end
    end

    always_comb begin
        prod_c = sfpp_mul(op_a_q, op_b_q);
`ifdef SFPP_ZERO_FLUSH_EN
        if ((op_a_q.exp == '0) || (op_b_q.exp == '0)) begin
            prod_c = {op_a_q.sign ^ op_b_q.sign, (WORD_W-1)'(0)};
        end
`endif
    end

    // Operand stage counts as the first stage; the rest carry the product.
    if (MUL_LAT == 1) begin : g_direct
        assign out_valid_o = op_v_q;
        assign out_tag_o   = op_tag_q;
        assign out_data_o  = prod_c;
    end else begin : g_stages
        localparam int unsigned NSTG = MUL_LAT - 1;

        logic             stg_v_q    [NSTG];
        logic [TAG_W-1:0] stg_tag_q  [NSTG];
        sfpp_t            stg_data_q [NSTG];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned k = 0; k < NSTG; k++) begin
                    stg_v_q[k] <= 1'b0;
                end
            end else begin
                stg_v_q[0] <= op_v_q;
                for (int unsigned k = 1; k < NSTG; k++) begin
                    stg_v_q[k] <= stg_v_q[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            stg_tag_q[0]  <= op_tag_q;
            stg_data_q[0] <= prod_c;
            for (int unsigned k = 1; k < NSTG; k++) begin
                stg_tag_q[k]  <= stg_tag_q[k-1];
                stg_data_q[k] <= stg_data_q[k-1];
            end
        end

        assign out_valid_o = stg_v_q[NSTG-1];
        assign out_tag_o   = stg_tag_q[NSTG-1];
        assign out_data_o  = stg_data_q[NSTG-1];
    end

endmodule

// File: rtl/sfpp_mult_arbiter.sv
// Round-robin sharing of one pipelined FP multiplier with a credit-protected tagged result FIFO.
// Build with SFPP_ZERO_FLUSH_EN defined to flush exp==0 operands to signed zero.
module sfpp_mult_arbiter
    import sfpp_pkg::*;
#(
    parameter  int unsigned NREQ       = 4,
    parameter  int unsigned MUL_LAT    = 2,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned TAG_W      = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [WORD_W*NREQ-1:0]   req_a,
    input  logic [WORD_W*NREQ-1:0]   req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WORD_W-1:0]        res_data,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0] infl_q, infl_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [TAG_W-1:0] mem_tag_q  [FIFO_DEPTH];
    sfpp_t            mem_data_q [FIFO_DEPTH];

    logic             gnt_vld_c;
    logic [TAG_W-1:0] gnt_idx_c;
    logic [TAG_W-1:0] scan_idx_c;
    logic             can_issue_c;
    logic             xfer_c;
    logic             pop_c;
    sfpp_t            sel_a_c;
    sfpp_t            sel_b_c;
    logic             push_c;
    logic [TAG_W-1:0] pipe_tag_c;
    sfpp_t            pipe_data_c;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        gnt_vld_c  = 1'b0;
        gnt_idx_c  = '0;
        scan_idx_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx_c = TAG_W'((32'(rr_ptr_q) + k) % NREQ);
            if (!gnt_vld_c && req_valid[scan_idx_c]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = scan_idx_c;
            end
        end
    end

    // Credits come only from registered state, so res_ready never reaches req_ready.
    assign can_issue_c = (SUM_W'(fifo_cnt_q) + SUM_W'(infl_q)) < SUM_W'(FIFO_DEPTH);
    assign xfer_c      = can_issue_c && gnt_vld_c && !rst;

    always_comb begin
        req_ready = '0;
        if (xfer_c) begin
            req_ready[gnt_idx_c] = 1'b1;
        end
    end

    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx_c == TAG_W'(i)) begin
                sel_a_c = req_a[WORD_W*i +: WORD_W];
                sel_b_c = req_b[WORD_W*i +: WORD_W];
            end
        end
    end

    sfpp_mul_pipe #(
        .MUL_LAT (MUL_LAT),
        .TAG_W   (TAG_W)
    ) u_mul_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (xfer_c),
        .in_tag_i    (gnt_idx_c),
        .in_a_i      (sel_a_c),
        .in_b_i      (sel_b_c),
        .out_valid_o (push_c),
        .out_tag_o   (pipe_tag_c),
        .out_data_o  (pipe_data_c)
    );

    assign res_valid = (fifo_cnt_q != '0);
    assign pop_c     = res_valid && res_ready;
    assign res_data  = mem_data_q[rd_ptr_q];
    assign res_tag   = mem_tag_q[rd_ptr_q];
    assign busy      = (infl_q != '0) || res_valid;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        infl_d     = infl_q + CNT_W'(xfer_c) - CNT_W'(push_c);
        if (xfer_c) begin
            rr_ptr_d = (gnt_idx_c == TAG_W'(NREQ - 1)) ? '0 : gnt_idx_c + TAG_W'(1);
        end
        if (push_c) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            infl_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            infl_q     <= infl_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_tag_q[wr_ptr_q]  <= pipe_tag_c;
            mem_data_q[wr_ptr_q] <= pipe_data_c;
        end
    end

endmodule

// File: tb/tb_sfpp_mult_arbiter.sv
// Scoreboard bench: requests are modelled at transfer time, a negedge monitor checks handshakes and results.
module tb_sfpp_mult_arbiter;

    localparam int NREQ       = 4;
    localparam int MUL_LAT    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [32*NREQ-1:0]     req_a;
    logic [32*NREQ-1:0]     req_b;
    logic                   res_valid;
    logic                   res_ready;
    logic [31:0]            res_data;
    logic [TAG_W-1:0]       res_tag;
    logic                   busy;

    always #5 clk = ~clk;

    sfpp_mult_arbiter #(
        .NREQ       (NREQ),
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        int               xcyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pend_exp [NREQ];
    bit          xfer_flag [NREQ];
    int          rr_m = 0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Real-number style multiply on mantissas 1.f, truncated, exponent wrapping modulo 256.
    function automatic logic [31:0] ref_mul(logic [31:0] a, logic [31:0] b);
        logic [47:0] p;
        int          e;
        logic [22:0] f;
`ifdef SFPP_ZERO_FLUSH_EN
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
`endif
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            f = p[46:24];
        end else begin
            f = p[45:23];
        end
        return {a[31] ^ b[31], 8'(e), f};
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        bit              exp_v;
        int              idx;
        if (rst) begin
            sb.delete();
            rr_m = 0;
            for (int i = 0; i < NREQ; i++) xfer_flag[i] = 1'b0;
        end else begin
            exp_rdy = '0;
            if (sb.size() < FIFO_DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (rr_m + k) % NREQ;
                    if (req_valid[TAG_W'(idx)] && exp_rdy == '0) exp_rdy[TAG_W'(idx)] = 1'b1;
                end
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            exp_v = (sb.size() > 0) && (cyc >= sb[0].xcyc + MUL_LAT + 1);
            chk("res_valid", 32'(res_valid), 32'(exp_v));
            chk("busy", 32'(busy), 32'(sb.size() > 0));
            if (exp_v && res_valid) begin
                chk("res_data", res_data, sb[0].data);
                chk("res_tag", 32'(res_tag), 32'(sb[0].tag));
            end
            if (exp_v && res_ready) void'(sb.pop_front());
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rdy[i]) begin
                    sb.push_back('{data: pend_exp[i], tag: TAG_W'(i), xcyc: cyc});
                    xfer_flag[i] = 1'b1;
                    rr_m = (i + 1) % NREQ;
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer_flag[i]) begin
                xfer_flag[i] = 1'b0;
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        pend_exp[i]       = e;
        req_valid[i]      = 1'b1;
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 254));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic issue_rand(input int i);
        logic [31:0] a;
        logic [31:0] b;
        a = rnd_fp();
        b = rnd_fp();
        issue(i, a, b, ref_mul(a, b));
    endtask

    task automatic refill(input int pct);
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 99) < pct) issue_rand(i);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (sb.size() != 0 || req_valid != '0); n++) step();
        chk("drain_outstanding", 32'(sb.size()), 32'd0);
        chk("drain_pending_req", 32'(req_valid), 32'd0);
    endtask

    logic [31:0] da [4];
    logic [31:0] db [4];
    logic [31:0] de [4];

    initial begin
        da[0] = 32'h40000000; db[0] = 32'h40400000; de[0] = 32'h40C00000;
        da[1] = 32'h3FC00000; db[1] = 32'h3FC00000; de[1] = 32'h40100000;
        da[2] = 32'hBF800000; db[2] = 32'h40000000; de[2] = 32'hC0000000;
`ifdef SFPP_ZERO_FLUSH_EN
        da[3] = 32'h80000000; db[3] = 32'h40400000; de[3] = 32'h80000000;
`else
        da[3] = 32'h00000000; db[3] = 32'h40400000; de[3] = 32'h00C00000;
`endif
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) pend_exp[i] = '0;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Directed single requests on requester 0.
        for (int t = 0; t < 4; t++) begin
            issue(0, da[t], db[t], de[t]);
            repeat (MUL_LAT + 4) step();
        end

        // All requesters continuously valid.
        repeat (40) begin
            step();
            refill(100);
        end
        drain();

        // Back-pressure fills the credits, then release.
        res_ready = 1'b0;
        repeat (12) begin
            step();
            refill(100);
        end
        res_ready = 1'b1;
        repeat (20) begin
            step();
            refill(100);
        end
        drain();

        // Random traffic and random consumer stalls.
        repeat (400) begin
            step();
            res_ready = ($urandom_range(0, 3) != 0);
            refill(40);
        end
        res_ready = 1'b1;
        drain();

        // Reset with work in flight and buffered.
        res_ready = 1'b0;
        repeat (4) begin
            step();
            refill(100);
        end
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst       = 1'b0;
        res_ready = 1'b1;
        issue_rand(1);
        issue_rand(3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sfpp_mult_arbiter.md
Name: sfpp_mult_arbiter

Overview:
Shares one pipelined single-precision floating-point multiplier among NREQ requesters.
- Round-robin arbitration with per-requester valid/ready handshake.
- Results are buffered in a credit-protected result FIFO and returned tagged with the originating requester index.
- Sits between the vector/scalar issue units and the FP datapath; the multiplier itself is an internal pipeline.

Parameters:
NREQ, 4, number of requesters (2..8)
MUL_LAT, 2, multiplier pipeline stages (1..4)
FIFO_DEPTH, 4, result FIFO entries (power of two, >= MUL_LAT)
TAG_W, clog2(NREQ), derived localparam, result tag width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept; at most one bit set per cycle
req_a  in  32*NREQ  operand A, slice i belongs to requester i
req_b  in  32*NREQ  operand B, slice i belongs to requester i
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer accepts head
res_data  out  32  product, IEEE-754 single layout {sign, exp[7:0], frac[22:0]}
res_tag  out  TAG_W  requester index of res_data
busy  out  1  any operation in pipeline or FIFO

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - rr_ptr=0, FIFO empty, all pipeline valid bits 0, in-flight count 0.
  - res_valid=0, req_ready=0, busy=0.
  - res_data and res_tag are don't-care while res_valid=0.
  - Reset mid-operation discards in-flight and buffered results; no result is emitted afterwards.
- Credits: credits = FIFO_DEPTH - fifo_count - in_flight. can_issue = (credits != 0).
  - A pop in the same cycle does not create credit until the next cycle. Conservative; no combinational path from res_ready to req_ready.
- Arbitration (combinational grant, registered pointer):
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[i] = can_issue && (grant == i).
  - Transfer occurs when req_valid[i] && req_ready[i]; at most one per cycle.
  - On transfer, rr_ptr <= (grant+1) mod NREQ. With no transfer, rr_ptr holds.
  - A requester must hold valid and operands stable until ready; the arbiter never drops a raised request.
  - Starvation bound: NREQ-1 other grants.
- Pipeline: operands and tag are captured at the transfer edge. The result is written to the FIFO MUL_LAT edges later.
  - Minimum transfer-to-res_valid latency is MUL_LAT+1 cycles.
  - Throughput is 1 per cycle while credits are available.
- FIFO: show-ahead. res_valid = !empty; pop on res_valid && res_ready. Simultaneous push and pop are allowed at any fill level, including full (only possible via credits) and empty (pass-through after one cycle, no bypass).
- in_flight counter: +1 on transfer, -1 on FIFO write; both in the same cycle leaves it unchanged.
- busy = (in_flight != 0) || !empty.
- Arithmetic (normal operands only):
  - sign = sa ^ sb.
  - P = {1,fa} * {1,fb}, 48 bits.
  - If P[47]: frac = P[46:24], exp = ea+eb-127+1; else frac = P[45:23], exp = ea+eb-127.
  - Truncate; no rounding.
  - Exponent computed in 10 bits, result is the low 8 bits; overflow/underflow wraps with no flags.
  - NaN/Inf are not special-cased.

Optional Feature:
SFPP_ZERO_FLUSH_EN:
- Defined: if either operand has exp==0, the result is {sa^sb, 31'b0}. Denormals and zeros flush to signed zero.
- Undefined: exp==0 operands go through normal arithmetic with the hidden bit assumed 1.

Decomposition:
- Package sfpp_pkg: SFPP_BIAS=8'd127, field widths (EXP_W=8, FRAC_W=23), and a packed struct type sfpp_t {sign, exp, frac}.
- Sub-module sfpp_mul_pipe: MUL_LAT-stage multiplier carrying valid and tag alongside the data.
- The arbiter, credit counter, and FIFO stay in the top module.

Test Plan:
- Single request, res_ready=1: req 0 sends 0x40000000 * 0x40400000 -> res_data=0x40C00000, tag=0, res_valid exactly MUL_LAT+1 cycles after transfer.
- Normalization and sign: 0x3FC00000*0x3FC00000 -> 0x40100000; 0xBF800000*0x40000000 -> 0xC0000000.
- All NREQ=4 valid continuously, res_ready=1 -> grants in order 0,1,2,3,0,... at one per cycle; tags return in the same order.
- res_ready=0 with continuous requests -> exactly FIFO_DEPTH transfers, then req_ready=0. Raise res_ready -> issue resumes one cycle after the first pop; no loss or duplication.
- Zero operand 0x80000000 * 0x40400000 -> 0x80000000 with SFPP_ZERO_FLUSH_EN. Operands 0x00000000 * 0x40400000 -> 0x00C00000 without it.
- Assert rst with 2 ops in flight and 2 in FIFO -> next cycle res_valid=0 and busy=0; the following request completes normally with rr_ptr starting at 0.
